// File: rtl/axis_converter_axil_pkg.sv
// Shared types and constants for the AXI-Stream to AXI-Lite command converter.
package axis_converter_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_WDATA,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    SEND
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axis_converter_axil.sv
// Converts AXI-Stream command beats into single AXI-Lite transactions.
// Define AXIS_CONVERTER_AXIL_WRITE_ACK_EN to return each write's bresp as a stream beat.
module axis_converter_axil
  import axis_converter_axil_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        areset,

  input  logic [AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                        s_axis_tuser,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,

  output logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,

  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,
  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready,

  output logic                        err_sticky
);

  state_t                    state, state_next;
  logic [AXI_ADDR_WIDTH-1:0] addr_n;
  logic [AXI_DATA_WIDTH-1:0] wdata_n, tdata_n;
  logic                      awvalid_n, wvalid_n, arvalid_n, tvalid_n, err_n;

  always_comb begin
    state_next = state;
    addr_n     = m_axil_awaddr;
    wdata_n    = m_axil_wdata;
    tdata_n    = m_axis_tdata;
    awvalid_n  = m_axil_awvalid;
    wvalid_n   = m_axil_wvalid;
    arvalid_n  = m_axil_arvalid;
    tvalid_n   = m_axis_tvalid;
    err_n      = err_sticky;

    unique case (state)
      IDLE: begin
        if (s_axis_tvalid && s_axis_tready) begin
          addr_n = s_axis_tdata[AXI_ADDR_WIDTH-1:0];
          if (s_axis_tuser == CMD_WRITE) begin
            state_next = GET_WDATA;
          end else begin
            state_next = RD_REQ;
            arvalid_n  = 1'b1;
          end
        end
      end
      GET_WDATA: begin
        if (s_axis_tvalid && s_axis_tready) begin
          wdata_n    = s_axis_tdata;
          awvalid_n  = 1'b1;
          wvalid_n   = 1'b1;
          state_next = WR_REQ;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; move on once neither is still pending
        if (m_axil_awvalid && m_axil_awready) awvalid_n = 1'b0;
        if (m_axil_wvalid && m_axil_wready)   wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (m_axil_bvalid && m_axil_bready) begin
          if (resp_is_error(m_axil_bresp)) err_n = 1'b1;
`ifdef AXIS_CONVERTER_AXIL_WRITE_ACK_EN
          tdata_n      = '0;
          tdata_n[1:0] = m_axil_bresp;
          tvalid_n     = 1'b1;
          state_next   = SEND;
`else
          state_next   = IDLE;
`endif
        end
      end
      RD_REQ: begin
        if (m_axil_arvalid && m_axil_arready) begin
          arvalid_n  = 1'b0;
          state_next = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axil_rvalid && m_axil_rready) begin
          if (resp_is_error(m_axil_rresp)) err_n = 1'b1;
          tdata_n    = m_axil_rdata;
          tvalid_n   = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (m_axis_tvalid && m_axis_tready) begin
          tvalid_n   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready outputs are registered from the state being entered, keeping inputs off them
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= IDLE;
      s_axis_tready  <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      err_sticky     <= 1'b0;
    end else begin
      state          <= state_next;
      s_axis_tready  <= (state_next == IDLE) || (state_next == GET_WDATA);
      m_axis_tdata   <= tdata_n;
      m_axis_tvalid  <= tvalid_n;
      m_axil_awaddr  <= addr_n;
      m_axil_awvalid <= awvalid_n;
      m_axil_wdata   <= wdata_n;
      m_axil_wstrb   <= '1;
      m_axil_wvalid  <= wvalid_n;
      m_axil_bready  <= (state_next == WR_RESP);
      m_axil_araddr  <= addr_n;
      m_axil_arvalid <= arvalid_n;
      m_axil_rready  <= (state_next == RD_RESP);
      err_sticky     <= err_n;
    end
  end

endmodule

// File: tb/tb_axis_converter_axil.sv
// Randomized bench for axis_converter_axil: memory-backed AXI-Lite slave, stream sink, reference memory model.
module tb_axis_converter_axil;
  import axis_converter_axil_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tuser = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;
  logic        err_sticky;

  axis_converter_axil #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_tready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(m_axil_rready),
    .err_sticky(err_sticky)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Address map rule shared by the slave and the reference model
  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [1:0] resp_for(input logic [31:0] a);
    case (a[11:8])
      4'hE:    return RESP_SLVERR;
      4'hD:    return RESP_DECERR;
      default: return RESP_OKAY;
    endcase
  endfunction

  // Reference model: memory contents and sticky error, updated per command
  logic [31:0] ref_mem [logic [31:0]];
  logic        ref_err = 1'b0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  // AXI-Lite slave, acting at the falling edge
  logic [31:0] slv_mem [logic [31:0]];
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, stab_err = 0;
  logic aw_pend = 0, w_pend = 0, b_pend = 0, r_pend = 0;
  logic [31:0] aw_seen = '0, w_seen = '0, ar_seen = '0;
  logic [3:0]  strb_seen = '0;
  logic        p_awvalid = 0, p_wvalid = 0, p_bready = 0, p_arvalid = 0, p_rready = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;

  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_pend = 0; w_pend = 0; b_pend = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
      end else begin
        if (p_awvalid && !awready && (!m_axil_awvalid || m_axil_awaddr !== p_awaddr)) stab_err++;
        if (p_wvalid && !wready && (!m_axil_wvalid || m_axil_wdata !== p_wdata)) stab_err++;
        if (p_arvalid && !arready && (!m_axil_arvalid || m_axil_araddr !== p_araddr)) stab_err++;
        if (awready && p_awvalid) begin aw_cnt++; aw_seen = p_awaddr; aw_pend = 1; end
        if (wready && p_wvalid) begin w_cnt++; w_seen = p_wdata; strb_seen = p_wstrb; w_pend = 1; end
        if (bvalid && p_bready) begin b_cnt++; bvalid = 0; end
        if (arready && p_arvalid) begin ar_cnt++; ar_seen = p_araddr; r_pend = 1; end
        if (rvalid && p_rready) rvalid = 0;
        if (aw_pend && w_pend) begin
          slv_mem[aw_seen] = w_seen;
          b_pend = 1; aw_pend = 0; w_pend = 0;
        end
        awready = 0;
        if (m_axil_awvalid && !aw_pend) begin
          if (aw_wait >= aw_delay) begin awready = 1; aw_wait = 0; end else aw_wait++;
        end
        wready = 0;
        if (m_axil_wvalid && !w_pend) begin
          if (w_wait >= w_delay) begin wready = 1; w_wait = 0; end else w_wait++;
        end
        if (b_pend && !bvalid) begin
          if (b_wait >= b_delay) begin
            bvalid = 1; bresp = resp_for(aw_seen); b_pend = 0; b_wait = 0;
          end else b_wait++;
        end
        arready = 0;
        if (m_axil_arvalid && !r_pend) begin
          if (ar_wait >= ar_delay) begin arready = 1; ar_wait = 0; end else ar_wait++;
        end
        if (r_pend && !rvalid) begin
          if (r_wait >= r_delay) begin
            rvalid = 1; r_pend = 0; r_wait = 0;
            rdata = slv_mem.exists(ar_seen) ? slv_mem[ar_seen] : default_word(ar_seen);
            rresp = resp_for(ar_seen);
          end else r_wait++;
        end
        p_awvalid = m_axil_awvalid; p_awaddr = m_axil_awaddr;
        p_wvalid = m_axil_wvalid; p_wdata = m_axil_wdata; p_wstrb = m_axil_wstrb;
        p_bready = m_axil_bready; p_arvalid = m_axil_arvalid; p_araddr = m_axil_araddr;
        p_rready = m_axil_rready;
      end
    end
  end

  // Response stream sink
  logic [31:0] rx_q[$];
  logic        sink_hold = 0, sink_stall = 0, p_tvalid = 0;
  logic [31:0] p_tdata = '0;
  int          first_valid_cyc = 0;

  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_tready = 0; p_tvalid = 0;
      end else begin
        if (p_tvalid && !m_tready && (!m_axis_tvalid || m_axis_tdata !== p_tdata)) stab_err++;
        if (p_tvalid && m_tready) rx_q.push_back(p_tdata);
        if (m_axis_tvalid && !p_tvalid) first_valid_cyc = cyc;
        m_tready = sink_hold ? 1'b0 : (sink_stall ? ($urandom_range(0, 3) != 0) : 1'b1);
        p_tvalid = m_axis_tvalid; p_tdata = m_axis_tdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // The main sequence acts 1 time unit after each falling edge
  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  int hs_cyc = 0;

  task automatic send_beat(input logic [31:0] d, input logic u);
    int n;
    s_tdata = d; s_tuser = u; s_tvalid = 1'b1; n = 0;
    while (!s_axis_tready && n < 200) begin tick(); n++; end
    check("s_axis_handshake", 32'(s_axis_tready), 32'd1);
    hs_cyc = cyc;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_rx(output logic [31:0] got);
    int n;
    n = 0;
    while (rx_q.size() == 0 && n < 200) begin tick(); n++; end
    check("m_axis_beat_arrived", 32'(rx_q.size() != 0), 32'd1);
    got = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hxxxx_xxxx;
  endtask

  task automatic do_read(input logic [31:0] a, input bit chk_lat);
    logic [31:0] exp, got;
    exp = ref_read(a);
    if (resp_for(a) != RESP_OKAY) ref_err = 1'b1;
    send_beat(a, CMD_READ);
    wait_rx(got);
    check("rd_data", got, exp);
    check("rd_araddr", ar_seen, a);
    if (chk_lat) check("rd_latency", 32'(first_valid_cyc - hs_cyc), 32'd3);
    check("rd_err_sticky", 32'(err_sticky), 32'(ref_err));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int aw0, w0, b0, n;
    logic [31:0] got;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    send_beat(a, CMD_WRITE);
    send_beat(d, 1'($urandom_range(0, 1)));
    n = 0;
    while (b_cnt == b0 && n < 200) begin tick(); n++; end
    tick();
    ref_mem[a] = d;
    if (resp_for(a) != RESP_OKAY) ref_err = 1'b1;
    check("wr_b_count", 32'(b_cnt - b0), 32'd1);
    check("wr_aw_count", 32'(aw_cnt - aw0), 32'd1);
    check("wr_w_count", 32'(w_cnt - w0), 32'd1);
    check("wr_awaddr", aw_seen, a);
    check("wr_wdata", w_seen, d);
    check("wr_wstrb", 32'(strb_seen), 32'hF);
`ifdef AXIS_CONVERTER_AXIL_WRITE_ACK_EN
    wait_rx(got);
    check("wr_ack_beat", got, {30'd0, resp_for(a)});
`else
    repeat (4) tick();
    got = 32'(rx_q.size());
    check("wr_no_beat", got, 32'd0);
`endif
    check("wr_err_sticky", 32'(err_sticky), 32'(ref_err));
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  initial begin
    logic [31:0] got, a;
    int rel_cyc, n, idx;

    ref_mem[32'h20] = 32'h1234_5678; slv_mem[32'h20] = 32'h1234_5678;
    ref_mem[32'hE00] = 32'h0000_BAD0; slv_mem[32'hE00] = 32'h0000_BAD0;

    // Reset values
    repeat (3) tick();
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_valids", {28'd0, m_axis_tvalid, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 32'd0);
    check("rst_readies", {30'd0, m_axil_bready, m_axil_rready}, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_awaddr", m_axil_awaddr, 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    areset = 1'b0;
    check("rst_release_tready", 32'(s_axis_tready), 32'd0);
    tick();
    check("post_rst_tready", 32'(s_axis_tready), 32'd1);

    // Zero-wait write then read
    set_delays(0, 0, 0, 0, 0);
    do_write(32'h10, 32'hDEAD_BEEF);
    do_read(32'h20, 1'b1);

    // AW/W acceptance orderings
    set_delays(0, 2, 0, 0, 0); do_write(32'h30, 32'h0000_1111);
    set_delays(2, 0, 1, 0, 0); do_write(32'h34, 32'h0000_2222);
    set_delays(0, 0, 0, 0, 0); do_write(32'h38, 32'h0000_3333);

    // Error response sets the sticky flag, which survives later OKAY commands
    do_read(32'hE00, 1'b0);
    do_read(32'h30, 1'b0);
    do_write(32'h3C, 32'h0000_4444);

    // Output back-pressure in SEND
    sink_hold = 1'b1;
    send_beat(32'h20, CMD_READ);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin tick(); n++; end
    check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
    s_tdata = 32'h44; s_tuser = CMD_READ; s_tvalid = 1'b1;
    repeat (5) begin
      tick();
      check("hold_tdata", m_axis_tdata, 32'h1234_5678);
      check("hold_s_tready", 32'(s_axis_tready), 32'd0);
    end
    rel_cyc = cyc;
    sink_hold = 1'b0;
    send_beat(32'h44, CMD_READ);
    check("hdr_after_release", 32'(hs_cyc > rel_cyc), 32'd1);
    wait_rx(got);
    check("held_beat", got, 32'h1234_5678);
    wait_rx(got);
    check("next_beat", got, ref_read(32'h44));

    // Reset in the middle of a write request
    set_delays(20, 20, 0, 0, 0);
    send_beat(32'h50, CMD_WRITE);
    send_beat(32'h5555_5555, CMD_READ);
    tick();
    check("midrst_awvalid_before", 32'(m_axil_awvalid & m_axil_wvalid), 32'd1);
    areset = 1'b1;
    #1;
    check("midrst_aw_w_valid", {30'd0, m_axil_awvalid, m_axil_wvalid}, 32'd0);
    check("midrst_s_tready", 32'(s_axis_tready), 32'd0);
    check("midrst_err", 32'(err_sticky), 32'd0);
    ref_err = 1'b0;
    tick(); tick();
    areset = 1'b0;
    set_delays(0, 0, 0, 0, 0);
    tick();
    check("midrst_tready_after", 32'(s_axis_tready), 32'd1);
    do_read(32'h40, 1'b1);
    do_read(32'h50, 1'b0);

    // Randomized command mix
    sink_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      idx = $urandom_range(0, 17);
      a = (idx < 16) ? 32'(idx * 4) : ((idx == 16) ? 32'hE04 : 32'hD08);
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
      else do_read(a, 1'b0);
    end

    tick();
    check("stability_violations", 32'(stab_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_converter_axil.md
AXIS_CONVERTER_AXIL -- requirements
Module: axis_converter_axil

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning data width of stream and AXI-Lite data channels.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning AXI-Lite address width; legal only if AXI_ADDR_WIDTH <= AXI_DATA_WIDTH.
REQ-003 SHALL have ports: aclk in 1 clock; areset in 1 asynchronous active-high reset (one clock only; reset asynchronous, active-high).
REQ-004 SHALL have ports: s_axis_tdata in DATA command stream data; s_axis_tuser in 1 command type on header beat (1 write, 0 read); s_axis_tvalid in 1; s_axis_tready out 1.
REQ-005 SHALL have ports: m_axis_tdata out DATA response stream data; m_axis_tvalid out 1; m_axis_tready in 1.
REQ-006 SHALL have AXI-Lite master ports m_axil_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready with standard directions and widths.
REQ-007 SHALL have port err_sticky out 1, set on any non-OKAY bresp/rresp.

Function
REQ-008 SHALL accept commands as header beat (address = tdata[AXI_ADDR_WIDTH-1:0], type = tuser) followed, for writes only, by one data beat.
REQ-009 SHALL use FSM states IDLE, GET_WDATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, SEND.
REQ-010 IDLE: s_axis_tready=1; header handshake registers address -> GET_WDATA (write) or RD_REQ (read).
REQ-011 GET_WDATA: s_axis_tready=1; data beat handshake registers wdata -> WR_REQ; tuser ignored on data beats.
REQ-012 WR_REQ: assert awvalid and wvalid together in first cycle; each drops independently on its own handshake; leave when both done -> WR_RESP; simultaneous or either-order acceptance SHALL be supported.
REQ-013 wstrb SHALL be all ones; awaddr/wdata SHALL be stable while valid.
REQ-014 WR_RESP: bready=1; on bvalid capture bresp -> SEND (macro defined) or IDLE (macro undefined).
REQ-015 RD_REQ: arvalid=1 until arready -> RD_RESP; RD_RESP: rready=1; on rvalid capture rdata -> SEND.
REQ-016 SEND: m_axis_tvalid=1, tdata stable until m_axis_tready -> IDLE; s_axis_tready=0 in all states except IDLE and GET_WDATA.
REQ-017 Only one outstanding AXI-Lite transaction SHALL exist; minimum read latency header-handshake to m_axis_tvalid = 3 cycles with zero-wait slave.
REQ-018 rdata SHALL be forwarded regardless of rresp; non-OKAY bresp/rresp SHALL set err_sticky on the capture cycle; err_sticky cleared only by reset.
REQ-019 All outputs SHALL be registered; no combinational path from any input to any valid/ready output.

Reset
REQ-020 areset asserted SHALL immediately force state IDLE, all valid outputs 0, all ready outputs 0, all data/address outputs 0, err_sticky 0.
REQ-021 Reset mid-transaction SHALL abandon it without completing handshakes; s_axis_tready SHALL go 1 on first clock edge after deassertion.

Configuration
REQ-022 With AXIS_CONVERTER_AXIL_WRITE_ACK_EN defined, each write SHALL emit one m_axis beat {zeros, bresp} via SEND; undefined, writes SHALL emit no m_axis beat and WR_RESP returns to IDLE.

Structure
REQ-023 Package axis_converter_axil_pkg SHALL hold the FSM state enum, AXI response constants (OKAY, EXOKAY, SLVERR, DECERR) and command-type constants.
REQ-024 SHALL be a single module with no sub-modules; a wrapper with flat ports is out of scope.

Verification
REQ-025 Write: header 0x0000_0010 tuser=1, data 0xDEAD_BEEF, zero-wait slave -> awaddr 0x10, wdata 0xDEADBEEF, wstrb 0xF; with macro m_axis beat 0x0, without none.
REQ-026 Read: header 0x0000_0020 tuser=0, slave returns 0x1234_5678 OKAY -> m_axis_tdata 0x12345678 at 3 cycles, err_sticky 0.
REQ-027 awready 2 cycles before wready, then reversed, then same cycle -> exactly one aw and one w handshake each, single bready handshake.
REQ-028 Read with rresp=SLVERR, rdata 0xBAD0 -> m_axis_tdata 0xBAD0, err_sticky 1 and held across later OKAY commands.
REQ-029 m_axis_tready held 0 for 5 cycles in SEND -> tdata stable, s_axis_tready 0, next header accepted only after release.
REQ-030 areset asserted during WR_REQ -> awvalid/wvalid 0 immediately; post-reset read of 0x40 completes normally.
